// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester arbiter: FSM encoding, mode values
// and a one-hot helper.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational winner picker: highest set index in fixed mode, or first set
// bit scanning upward from base (wrapping) in round-robin mode.
module prio_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] cand,
    input  logic [IDX_W-1:0]   base,
    input  logic               rr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;

    // rot[k] holds cand[(base+k) mod 4], so the lowest set bit of rot is the
    // first candidate encountered when scanning from base.
    always_comb begin
        dbl = {cand, cand} >> base;
        rot = dbl[NUM_REQ-1:0];
    end

    always_comb begin
        idx = '0;
        off = '0;
        any = |cand;
        if (rr) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (rot[k]) begin
                    off = IDX_W'(k);
                end
            end
            idx = base + off;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cand[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester arbiter with fixed-priority or round-robin selection,
// registered one-hot grant, and a bounded hold when others are waiting.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no grant outstanding; any request is granted on the next edge
//  GRANT | holder in gnt_idx owns the resource; hold_cnt counts tenure
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mode,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    localparam int               CNT_W   = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]    last_idx_q, last_idx_d;
    logic [IDX_W-1:0]    holder_d;

    logic [NUM_REQ-1:0]  others;
    logic [NUM_REQ-1:0]  cand;
    logic [IDX_W-1:0]    scan_base;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;
    logic                holder_req;

    always_comb begin
        others     = req & ~idx_to_onehot(gnt_idx);
        holder_req = req[gnt_idx];
        cand       = (state_q == GRANT) ? others : req;
        scan_base  = last_idx_q + IDX_W'(1);
    end

    prio_pick4 u_pick (
        .cand (cand),
        .base (scan_base),
        .rr   (mode == MODE_RR),
        .idx  (win_idx),
        .any  (win_any)
    );

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_idx_d = last_idx_q;
        holder_d   = gnt_idx;

        unique case (state_q)
            IDLE: begin
                holder_d = '0;
                if (win_any) begin
                    state_d    = GRANT;
                    holder_d   = win_idx;
                    hold_cnt_d = '0;
                    last_idx_d = win_idx;
                end
            end
            GRANT: begin
                // Both release and timeout hand over straight to the best
                // other requester so the resource never idles needlessly.
                if ((!holder_req || hold_cnt_q == CNT_MAX) && win_any) begin
                    holder_d   = win_idx;
                    hold_cnt_d = '0;
                    last_idx_d = win_idx;
                end else if (!holder_req) begin
                    state_d    = IDLE;
                    holder_d   = '0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            last_idx_q <= IDX_W'(NUM_REQ - 1);
            gnt        <= '0;
            gnt_idx    <= '0;
            gnt_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_idx_q <= last_idx_d;
            gnt        <= (state_d == GRANT) ? idx_to_onehot(holder_d) : '0;
            gnt_idx    <= holder_d;
            gnt_valid  <= (state_d == GRANT);
        end
    end

endmodule
